// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Holds the FSM encoding and the packed pipeline-control bundle.
package pipeline_stall_ctrl_pkg;

    localparam int CNT_W_DEF       = 32;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic if_id_flush;
        logic id_ex_we;
        logic id_ex_flush;
        logic ex_mem_we;
        logic mem_wb_flush;
        logic mem_wait;
    } ctrl_t;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Count visible one cycle after the event; no backpressure.
module pipeline_stall_ctrl_sat_counter #(
    parameter int W = 32
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline hazard/memory-wait controller: combinational priority decode of write enables and flushes.
// Zero-latency (Mealy) controls; a data-memory wait freezes the pipe and may time out into a sticky HALT.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_hazard_in,
    input  logic             branch_taken_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             pc_write_en,
    output logic             IF_ID_write_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_write_en,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write_en,
    output logic             MEM_WB_flush,
    output logic             mem_wait_o,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W:0] TMO = MEM_TIMEOUT[WCNT_W:0];

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [WCNT_W:0]   wait_inc;
    logic              err_q, err_nxt;
    logic              freeze, timeout_hit;
    logic              stall_inc, flush_inc;
    ctrl_t             ctrl;

    assign freeze      = dmem_req_MEM & ~dmem_ready;
    assign wait_inc    = {1'b0, wait_cnt} + {{WCNT_W{1'b0}}, 1'b1};
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_inc >= TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err_q;
        ctrl         = '0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (state == ST_HALT) begin
            ctrl.mem_wait = 1'b1;
            stall_inc     = 1'b1;
        end else if (freeze) begin
            // Whole front end holds; MEM/WB takes bubbles until the access completes.
            ctrl.mem_wb_flush = 1'b1;
            ctrl.mem_wait     = 1'b1;
            stall_inc         = 1'b1;
            wait_cnt_nxt      = wait_inc[WCNT_W-1:0];
            if (state == ST_RUN) begin
                state_nxt = ST_WAIT;
            end else if (timeout_hit) begin
                state_nxt = ST_HALT;
                err_nxt   = 1'b1;
            end
        end else begin
            state_nxt    = ST_RUN;
            wait_cnt_nxt = '0;
            ctrl.pc_we     = 1'b1;
            ctrl.if_id_we  = 1'b1;
            ctrl.id_ex_we  = 1'b1;
            ctrl.ex_mem_we = 1'b1;
            if (branch_taken_EX) begin
                ctrl.if_id_flush = 1'b1;
                ctrl.id_ex_flush = 1'b1;
                flush_inc        = 1'b1;
            end else if (load_use_hazard_in) begin
                ctrl.pc_we       = 1'b0;
                ctrl.if_id_we    = 1'b0;
                ctrl.id_ex_flush = 1'b1;
                stall_inc        = 1'b1;
            end
        end
    end

    // Reset overrides every control combinationally, not just at the next edge.
    assign pc_write_en     = ctrl.pc_we        & rst_n;
    assign IF_ID_write_en  = ctrl.if_id_we     & rst_n;
    assign IF_ID_flush     = ctrl.if_id_flush  & rst_n;
    assign ID_EX_write_en  = ctrl.id_ex_we     & rst_n;
    assign ID_EX_flush     = ctrl.id_ex_flush  & rst_n;
    assign EX_MEM_write_en = ctrl.ex_mem_we    & rst_n;
    assign MEM_WB_flush    = ctrl.mem_wb_flush & rst_n;
    assign mem_wait_o      = ctrl.mem_wait     & rst_n;
    assign mem_timeout_err = err_q & rst_n;

    pipeline_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    pipeline_stall_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench: two controllers (timeout 4 / 8-bit counters, timeout disabled / 4-bit counters) on shared stimulus,
// directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lu = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;

    logic a_pc, a_ifwe, a_iffl, a_idwe, a_idfl, a_exwe, a_wbfl, a_wait, a_err;
    logic b_pc, b_ifwe, b_iffl, b_idwe, b_idfl, b_exwe, b_wbfl, b_wait, b_err;
    logic [7:0] stall_a, flush_a;
    logic [3:0] stall_b, flush_b;
    logic [7:0] vec_a, vec_b;

    assign vec_a = {a_pc, a_ifwe, a_iffl, a_idwe, a_idfl, a_exwe, a_wbfl, a_wait};
    assign vec_b = {b_pc, b_ifwe, b_iffl, b_idwe, b_idfl, b_exwe, b_wbfl, b_wait};

    localparam logic [7:0] V_HALT  = 8'b0000_0001;
    localparam logic [7:0] V_FRZ   = 8'b0000_0011;
    localparam logic [7:0] V_BR    = 8'b1111_1100;
    localparam logic [7:0] V_LU    = 8'b0001_1100;
    localparam logic [7:0] V_NORM  = 8'b1101_0100;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .load_use_hazard_in(lu), .branch_taken_EX(br),
        .dmem_req_MEM(req), .dmem_ready(rdy),
        .pc_write_en(a_pc), .IF_ID_write_en(a_ifwe), .IF_ID_flush(a_iffl),
        .ID_EX_write_en(a_idwe), .ID_EX_flush(a_idfl), .EX_MEM_write_en(a_exwe),
        .MEM_WB_flush(a_wbfl), .mem_wait_o(a_wait), .mem_timeout_err(a_err),
        .stall_cycles(stall_a), .flush_events(flush_a)
    );

    pipeline_stall_ctrl #(.MEM_TIMEOUT(0), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .load_use_hazard_in(lu), .branch_taken_EX(br),
        .dmem_req_MEM(req), .dmem_ready(rdy),
        .pc_write_en(b_pc), .IF_ID_write_en(b_ifwe), .IF_ID_flush(b_iffl),
        .ID_EX_write_en(b_idwe), .ID_EX_flush(b_idfl), .EX_MEM_write_en(b_exwe),
        .MEM_WB_flush(b_wbfl), .mem_wait_o(b_wait), .mem_timeout_err(b_err),
        .stall_cycles(stall_b), .flush_events(flush_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: halted flag, consecutive frozen cycles, stall count, flush count, sticky error.
    bit ha, hb, ea, eb;
    int ca, cb, sa, sb, fa, fb;
    // Expectations for the cycle currently presented (counters are pre-edge values).
    logic [7:0] exp_a, exp_b;
    int xs_a, xf_a, xs_b, xf_b;
    bit xe_a, xe_b;

    task automatic model(input bit m_req, m_rdy, m_br, m_lu, input int tmo, input int w,
                         inout bit h, inout int c, inout int s, inout int f, inout bit e,
                         output logic [7:0] v, output int xs, output int xf, output bit xe);
        int maxc;
        maxc = (1 << w) - 1;
        xs = s; xf = f; xe = e;
        if (h) begin
            v = V_HALT; s++;
        end else if (m_req && !m_rdy) begin
            v = V_FRZ; s++; c++;
            if (tmo != 0 && c == tmo) begin h = 1; e = 1; end
        end else begin
            c = 0;
            if (m_br) begin v = V_BR; f++; end
            else if (m_lu) begin v = V_LU; s++; end
            else v = V_NORM;
        end
        if (s > maxc) s = maxc;
        if (f > maxc) f = maxc;
    endtask

    task automatic step(input bit s_req, s_rdy, s_br, s_lu);
        @(negedge clk);
        req = s_req; rdy = s_rdy; br = s_br; lu = s_lu;
        #1;
        model(s_req, s_rdy, s_br, s_lu, 4, 8, ha, ca, sa, fa, ea, exp_a, xs_a, xf_a, xe_a);
        model(s_req, s_rdy, s_br, s_lu, 0, 4, hb, cb, sb, fb, eb, exp_b, xs_b, xf_b, xe_b);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        req = 0; rdy = 0; br = 0; lu = 0;
        rst_n = 1'b1;
        ha = 0; hb = 0; ea = 0; eb = 0; ca = 0; cb = 0; sa = 0; sb = 0; fa = 0; fb = 0;
    endtask

    task automatic test_reset();
        req = 1; rdy = 0; br = 1; lu = 1;
        assert_reset();
        n_cmp++; if (vec_a !== 8'h00) begin n_bad++; $display("FAIL reset_outs_a got %b want 00000000", vec_a); end
        n_cmp++; if (vec_b !== 8'h00) begin n_bad++; $display("FAIL reset_outs_b got %b want 00000000", vec_b); end
        n_cmp++; if ({stall_a, flush_a, a_err} !== 17'd0) begin n_bad++; $display("FAIL reset_cnt_a stall=%0d flush=%0d err=%b want 0", stall_a, flush_a, a_err); end
        release_reset();
        step(0, 0, 0, 0);
        n_cmp++; if (vec_a !== V_NORM) begin n_bad++; $display("FAIL reset_idle got %b want %b", vec_a, V_NORM); end
    endtask

    task automatic test_load_use();
        assert_reset(); release_reset();
        step(0, 0, 0, 1);
        n_cmp++; if (vec_a !== V_LU) begin n_bad++; $display("FAIL lu_outs got %b want %b", vec_a, V_LU); end
        n_cmp++; if (stall_a !== 8'd0) begin n_bad++; $display("FAIL lu_stall_before got %0d want 0", stall_a); end
        step(0, 0, 0, 0);
        n_cmp++; if (vec_a !== V_NORM) begin n_bad++; $display("FAIL lu_after got %b want %b", vec_a, V_NORM); end
        n_cmp++; if (stall_a !== 8'd1) begin n_bad++; $display("FAIL lu_stall got %0d want 1", stall_a); end
    endtask

    task automatic test_branch_load_use();
        assert_reset(); release_reset();
        step(0, 0, 1, 1);
        n_cmp++; if (vec_a !== V_BR) begin n_bad++; $display("FAIL br_lu_outs got %b want %b", vec_a, V_BR); end
        step(0, 0, 0, 0);
        n_cmp++; if (flush_a !== 8'd1) begin n_bad++; $display("FAIL br_lu_flush got %0d want 1", flush_a); end
        n_cmp++; if (stall_a !== 8'd0) begin n_bad++; $display("FAIL br_lu_stall got %0d want 0", stall_a); end
    endtask

    task automatic test_mem_wait();
        assert_reset(); release_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            n_cmp++; if (vec_a !== V_FRZ) begin n_bad++; $display("FAIL wait_frz[%0d] got %b want %b", i, vec_a, V_FRZ); end
        end
        step(1, 1, 0, 0);
        n_cmp++; if (vec_a !== V_NORM) begin n_bad++; $display("FAIL wait_done got %b want %b", vec_a, V_NORM); end
        step(0, 0, 0, 0);
        n_cmp++; if (stall_a !== 8'd3) begin n_bad++; $display("FAIL wait_stall got %0d want 3", stall_a); end
    endtask

    task automatic test_timeout();
        assert_reset(); release_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 0);
            n_cmp++; if (vec_a !== V_FRZ || a_err !== 1'b0) begin n_bad++; $display("FAIL tmo_frz[%0d] got %b err=%b want %b err=0", i, vec_a, a_err, V_FRZ); end
        end
        step(1, 1, 1, 0);
        n_cmp++; if (vec_a !== V_HALT || a_err !== 1'b1) begin n_bad++; $display("FAIL tmo_halt got %b err=%b want %b err=1", vec_a, a_err, V_HALT); end
        n_cmp++; if (vec_b !== V_BR || b_err !== 1'b0) begin n_bad++; $display("FAIL tmo_disabled got %b err=%b want %b err=0", vec_b, b_err, V_BR); end
        step(0, 0, 0, 0);
        n_cmp++; if (vec_a !== V_HALT) begin n_bad++; $display("FAIL tmo_stuck got %b want %b", vec_a, V_HALT); end
        assert_reset();
        n_cmp++; if (a_err !== 1'b0 || stall_a !== 8'd0) begin n_bad++; $display("FAIL tmo_rst err=%b stall=%0d want 0", a_err, stall_a); end
        release_reset();
        step(0, 0, 0, 0);
        n_cmp++; if (vec_a !== V_NORM) begin n_bad++; $display("FAIL tmo_rerun got %b want %b", vec_a, V_NORM); end
    endtask

    task automatic test_branch_during_freeze();
        assert_reset(); release_reset();
        step(1, 0, 1, 0);
        n_cmp++; if (vec_a !== V_FRZ) begin n_bad++; $display("FAIL bf_frz got %b want %b", vec_a, V_FRZ); end
        step(1, 1, 1, 0);
        n_cmp++; if (vec_a !== V_BR) begin n_bad++; $display("FAIL bf_release got %b want %b", vec_a, V_BR); end
        step(0, 0, 0, 0);
        n_cmp++; if (flush_a !== 8'd1) begin n_bad++; $display("FAIL bf_flush got %0d want 1", flush_a); end
    endtask

    task automatic test_saturation();
        assert_reset(); release_reset();
        for (int i = 0; i < 20; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        n_cmp++; if (stall_b !== 4'd15) begin n_bad++; $display("FAIL sat_stall_b got %0d want 15", stall_b); end
        n_cmp++; if (stall_a !== 8'd20) begin n_bad++; $display("FAIL sat_stall_a got %0d want 20", stall_a); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ((ha && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
                assert_reset();
                n_cmp++; if (vec_a !== 8'h00 || stall_a !== 8'd0 || a_err !== 1'b0) begin n_bad++; $display("FAIL rnd_rst[%0d] outs=%b stall=%0d err=%b want 0", i, vec_a, stall_a, a_err); end
                release_reset();
            end else begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
                n_cmp++; if (vec_a !== exp_a || a_err !== xe_a) begin n_bad++; $display("FAIL rnd_a[%0d] outs=%b err=%b want %b err=%b", i, vec_a, a_err, exp_a, xe_a); end
                n_cmp++; if ({24'd0, stall_a} !== xs_a || {24'd0, flush_a} !== xf_a) begin n_bad++; $display("FAIL rnd_cnt_a[%0d] stall=%0d flush=%0d want %0d %0d", i, stall_a, flush_a, xs_a, xf_a); end
                n_cmp++; if (vec_b !== exp_b || b_err !== xe_b) begin n_bad++; $display("FAIL rnd_b[%0d] outs=%b err=%b want %b err=%b", i, vec_b, b_err, exp_b, xe_b); end
                n_cmp++; if ({28'd0, stall_b} !== xs_b || {28'd0, flush_b} !== xf_b) begin n_bad++; $display("FAIL rnd_cnt_b[%0d] stall=%0d flush=%0d want %0d %0d", i, stall_b, flush_b, xs_b, xf_b); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_mem_wait();
        test_timeout();
        test_branch_during_freeze();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
